// File: rtl/conv_result_collector.sv
// Cross-channel result collector: captures per-channel accumulates, sums them, adds bias,
// saturates and queues results in a FWFT FIFO. Optional macro RESULT_COLLECTOR_RELU_EN adds ReLU after saturation.
//
// state     | meaning
// ----------+-------------------------------------------------------
// S_COLLECT | waiting for every channel flag; captures always active
// S_ACC     | summing one snapshot word per cycle
// S_SAT     | add bias, clamp to signed DATA_WIDTH, register result
// S_PUSH    | write result into the output FIFO
module conv_result_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic [CHANNELS*DATA_WIDTH-1:0]   cSum,
    input  logic [CHANNELS-1:0]              cReady,
    input  logic [DATA_WIDTH-1:0]            bias,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             overflow,
    output logic                             busy
);

    localparam int ACC_W  = DATA_WIDTH + $clog2(CHANNELS) + 2;
    localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int WORK_N = 1 << IDX_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic signed [DATA_WIDTH-1:0] MAX_D = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] MIN_D = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_COLLECT, S_ACC, S_SAT, S_PUSH} state_t;

    state_t                         r_state, w_next;
    logic [CHANNELS-1:0]            r_ready_prev, r_flag;
    logic signed [DATA_WIDTH-1:0]   r_cap  [CHANNELS];
    logic signed [DATA_WIDTH-1:0]   r_work [WORK_N];
    logic signed [ACC_W-1:0]        r_acc;
    logic [IDX_W-1:0]               r_idx;
    logic [DATA_WIDTH-1:0]          r_result;

    logic [DATA_WIDTH-1:0]          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]               r_rd, r_wr;
    logic [CNT_W-1:0]               r_count;
    logic                           r_ovf;
    logic [DATA_WIDTH-1:0]          r_last;

    logic [CHANNELS-1:0]            w_rise;
    logic                           w_all, w_start;
    logic signed [ACC_W-1:0]        w_sum;
    logic [DATA_WIDTH-1:0]          w_sat;
    logic                           w_push, w_pop, w_full, w_wr_en;

    assign w_rise  = cReady & ~r_ready_prev;
    assign w_all   = &r_flag;
    assign w_start = (r_state == S_COLLECT) && w_all;

    // Edge detector keeps tracking through clear so a held level is not re-counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ready_prev <= '0;
        else        r_ready_prev <= cReady;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= '0;
            for (int n = 0; n < CHANNELS; n++) r_cap[n] <= '0;
        end else if (clear) begin
            r_flag <= '0;
            for (int n = 0; n < CHANNELS; n++) r_cap[n] <= '0;
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                if (w_rise[n]) begin
                    r_cap[n]  <= cSum[n*DATA_WIDTH +: DATA_WIDTH];
                    r_flag[n] <= 1'b1;
                end else if (w_start) begin
                    r_flag[n] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_COLLECT: if (w_all) w_next = S_ACC;
            S_ACC:     if (r_idx == IDX_W'(CHANNELS - 1)) w_next = S_SAT;
            S_SAT:     w_next = S_PUSH;
            S_PUSH:    w_next = S_COLLECT;
            default:   w_next = S_COLLECT;
        endcase
    end

    assign w_sum = r_acc + ACC_W'($signed(bias));

    always_comb begin
        w_sat = w_sum[DATA_WIDTH-1:0];
        if (w_sum > ACC_W'(MAX_D))      w_sat = MAX_D;
        else if (w_sum < ACC_W'(MIN_D)) w_sat = MIN_D;
`ifdef RESULT_COLLECTOR_RELU_EN
        if (w_sat[DATA_WIDTH-1]) w_sat = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_COLLECT;
            r_acc    <= '0;
            r_idx    <= '0;
            r_result <= '0;
            for (int n = 0; n < WORK_N; n++) r_work[n] <= '0;
        end else if (clear) begin
            r_state  <= S_COLLECT;
            r_acc    <= '0;
            r_idx    <= '0;
            r_result <= '0;
            for (int n = 0; n < WORK_N; n++) r_work[n] <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_COLLECT: if (w_all) begin
                    for (int n = 0; n < CHANNELS; n++) r_work[n] <= r_cap[n];
                    r_acc <= '0;
                    r_idx <= '0;
                end
                S_ACC: begin
                    r_acc <= r_acc + ACC_W'(r_work[r_idx]);
                    r_idx <= r_idx + IDX_W'(1);
                end
                S_SAT:   r_result <= w_sat;
                default: ;
            endcase
        end
    end

    // When full, a push is only accepted if the head leaves in the same cycle.
    assign w_push  = (r_state == S_PUSH) && !clear;
    assign w_pop   = m_valid && m_ready;
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr] <= r_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_last  <= '0;
        end else if (clear) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_last  <= '0;
        end else begin
            if (w_pop) begin
                r_rd   <= r_rd + PTR_W'(1);
                r_last <= r_mem[r_rd];
            end
            if (w_wr_en)     r_wr  <= r_wr + PTR_W'(1);
            else if (w_push) r_ovf <= 1'b1;
            if (w_wr_en && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_wr_en && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    assign m_valid    = (r_count != '0);
    assign m_data     = m_valid ? r_mem[r_rd] : r_last;
    assign fifo_count = r_count;
    assign overflow   = r_ovf;
    assign busy       = (r_state != S_COLLECT);

endmodule

// File: tb/tb_conv_result_collector.sv
// Randomized self-checking bench for conv_result_collector (3 channels, 4-deep FIFO),
// compared against an arithmetic reference model and a queue scoreboard.
module tb_conv_result_collector;

    localparam int DW = 32;
    localparam int CH = 3;
    localparam int FD = 4;

    logic           clk;
    logic           rst_n;
    logic           clear;
    logic [CH*DW-1:0] cSum;
    logic [CH-1:0]  cReady;
    logic [DW-1:0]  bias;
    logic [DW-1:0]  m_data;
    logic           m_valid;
    logic           m_ready;
    logic [2:0]     fifo_count;
    logic           overflow;
    logic           busy;

    int             n_pass   = 0;
    int             n_checks = 0;
    logic [DW-1:0]  q[$];
    bit             ovf_m    = 1'b0;
    logic [DW-1:0]  last_pop = '0;
    logic [DW-1:0]  ra, rb, rc, rbias;

    conv_result_collector #(.DATA_WIDTH(DW), .CHANNELS(CH), .FIFO_DEPTH(FD)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .cSum       (cSum),
        .cReady     (cReady),
        .bias       (bias),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Sum of channels plus bias in wide integer arithmetic, clamped to signed 32-bit.
    function automatic logic [DW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] c, input logic [DW-1:0] d);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b)) + longint'($signed(c)) + longint'($signed(d));
        if (s > 64'sd2147483647)       s = 64'sd2147483647;
        else if (s < -64'sd2147483648) s = -64'sd2147483648;
`ifdef RESULT_COLLECTOR_RELU_EN
        if (s < 0) s = 0;
`endif
        return s[DW-1:0];
    endfunction

    task automatic send(input logic [DW-1:0] v0, input logic [DW-1:0] v1, input logic [DW-1:0] v2,
                        input logic [DW-1:0] b, input bit hold, input bit pop_at_push,
                        input bit clear_in_acc);
        logic [DW-1:0] v [CH];
        int            order [CH];
        int            tmp, j;
        logic [DW-1:0] exp_r;
        v[0] = v0; v[1] = v1; v[2] = v2;
        exp_r = model(v0, v1, v2, b);
        for (int i = 0; i < CH; i++) order[i] = i;
        for (int i = CH - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        @(posedge clk); #1;
        cReady = '0;
        bias   = b;
        @(posedge clk); #1;
        for (int k = 0; k < CH; k++) begin
            cSum[order[k]*DW +: DW] = v[order[k]];
            cReady[order[k]] = 1'b1;
            @(posedge clk); #1;
            if (!hold) cReady[order[k]] = 1'b0;
            cSum[order[k]*DW +: DW] = $urandom;
            if (k < CH - 1) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        @(negedge clk);
        chk("busy_collect", {63'd0, busy}, 64'd0);
        for (int n = 1; n <= CH + 3; n++) begin
            @(posedge clk); #1;
            if (clear_in_acc && n == 1) clear = 1'b1;
            if (n == 2) clear = 1'b0;
            if (pop_at_push && n == CH + 2) m_ready = 1'b1;
            if (pop_at_push && n == CH + 3) m_ready = 1'b0;
            @(negedge clk);
            if (n == 1) chk("busy_acc", {63'd0, busy}, 64'd1);
            if (clear_in_acc && n == 2) begin
                q.delete();
                ovf_m = 1'b0;
                last_pop = '0;
                chk("clear_busy", {63'd0, busy}, 64'd0);
                chk("clear_count", {61'd0, fifo_count}, 64'd0);
                chk("clear_ovf", {63'd0, overflow}, 64'd0);
            end
            if (n == CH + 2) begin
                chk("count_pre_push", {61'd0, fifo_count}, 64'(q.size()));
                if (pop_at_push) begin
                    chk("pop_at_push_data", {32'd0, m_data}, {32'd0, q[0]});
                    last_pop = q.pop_front();
                end
            end
            if (n == CH + 3) begin
                if (!clear_in_acc) begin
                    if (q.size() < FD) q.push_back(exp_r);
                    else ovf_m = 1'b1;
                end
                chk("count_post_push", {61'd0, fifo_count}, 64'(q.size()));
                chk("overflow", {63'd0, overflow}, {63'd0, ovf_m});
                chk("valid", {63'd0, m_valid}, {63'd0, (q.size() != 0)});
                if (q.size() != 0) chk("head_data", {32'd0, m_data}, {32'd0, q[0]});
            end
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        @(posedge clk); #1;
        m_ready = 1'b1;
        while (q.size() > 0 && guard < 2 * FD) begin
            @(negedge clk);
            chk("drain_valid", {63'd0, m_valid}, 64'd1);
            chk("drain_data", {32'd0, m_data}, {32'd0, q[0]});
            last_pop = q.pop_front();
            @(posedge clk); #1;
            guard++;
        end
        m_ready = 1'b0;
        @(negedge clk);
        chk("drain_count", {61'd0, fifo_count}, 64'd0);
        chk("drain_valid_low", {63'd0, m_valid}, 64'd0);
        chk("drain_hold", {32'd0, m_data}, {32'd0, last_pop});
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        q.delete();
        ovf_m = 1'b0;
        last_pop = '0;
        chk("clr_count", {61'd0, fifo_count}, 64'd0);
        chk("clr_ovf", {63'd0, overflow}, 64'd0);
        chk("clr_valid", {63'd0, m_valid}, 64'd0);
        chk("clr_data", {32'd0, m_data}, 64'd0);
        chk("clr_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; cSum = '0; cReady = '0; bias = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_data", {32'd0, m_data}, 64'd0);
        chk("rst_count", {61'd0, fifo_count}, 64'd0);
        chk("rst_ovf", {63'd0, overflow}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        send(32'd100, -32'sd50, 32'd7, -32'sd7, 1'b1, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("no_second_result", {61'd0, fifo_count}, 64'd1);
        cReady = '0;

        send(32'h7FFFFFF0, 32'h7FFFFFF0, 32'd0, 32'h20, 1'b0, 1'b0, 1'b0);
        send(32'h80000000, 32'h80000000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        send(-32'sd10, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        drain();

        do_clear();
        for (int k = 1; k <= 5; k++) send(32'(k), 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        drain();
        chk("overflow_sticky", {63'd0, overflow}, 64'd1);

        do_clear();
        for (int k = 11; k <= 14; k++) send(32'(k), 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        send(32'd15, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        drain();

        send(32'd21, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        send(32'd33, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1);
        send(32'd40, 32'd2, 32'd0, -32'sd1, 1'b0, 1'b0, 1'b0);
        drain();

        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                ra = $urandom; rb = $urandom; rc = $urandom; rbias = $urandom;
            end else begin
                ra    = 32'(int'($urandom_range(0, 2000)) - 1000);
                rb    = 32'(int'($urandom_range(0, 2000)) - 1000);
                rc    = 32'(int'($urandom_range(0, 2000)) - 1000);
                rbias = 32'(int'($urandom_range(0, 200)) - 100);
            end
            send(ra, rb, rc, rbias, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_result_collector.md
Name: conv_result_collector

Overview:
- Downstream stage of the per-channel integer matrix accelerators.
- Captures each channel's final accumulate (cSum/cReady) and sums across channels sequentially.
- Adds a bias, saturates to signed 32-bit, and queues results in an output FIFO that drains over a valid/ready stream toward the PS-side DMA/readback path.

Parameters:
- DATA_WIDTH, 32, width of each channel's cSum and of the output word
- CHANNELS, 1, number of accelerator channels feeding the block
- FIFO_DEPTH, 16, output FIFO entries; power of two, >= 2

Ports:
- clk  in  1  block clock
- rst_n  in  1  reset
- clear  in  1  synchronous soft clear (driven by the vsm_ma reset)
- cSum  in  CHANNELS*DATA_WIDTH  per-channel signed accumulates; channel n at [n*DATA_WIDTH +: DATA_WIDTH]
- cReady  in  CHANNELS  per-channel ready; pulse or level
- bias  in  DATA_WIDTH  signed bias; sampled in SAT state
- m_data  out  DATA_WIDTH  FIFO head word
- m_valid  out  1  FIFO not empty
- m_ready  in  1  consumer accepts head
- fifo_count  out  $clog2(FIFO_DEPTH+1)  occupied entries
- overflow  out  1  sticky; a result was dropped
- busy  out  1  high in ACC, SAT, PUSH

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - m_valid=0, m_data=0, fifo_count=0, overflow=0, busy=0.
  - FSM=COLLECT; all capture flags and registers cleared.
- Capture:
  - A 0->1 edge of cReady[n] (registered previous value) latches cSum[n] into cap[n] and sets flag[n].
  - A level held high counts once.
  - A new edge while flag[n] is already set overwrites cap[n].
- FSM:
  - COLLECT: when all flags are set, go to ACC on the next edge. On that transition, snapshot cap[] into work[], clear all flags, set acc=0, idx=0. A capture edge in the same cycle as flag clear wins (flag set, cap updated, work gets the old value).
  - ACC: each cycle acc += sign-extend(work[idx]), idx++. After CHANNELS cycles, go to SAT. acc width is DATA_WIDTH+$clog2(CHANNELS)+2, signed.
  - SAT: r = acc + sign-extend(bias). Clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], register as result, go to PUSH.
  - PUSH: write result to FIFO, go to COLLECT. Captures continue in all states.
- Latency: with the FIFO empty, m_valid rises exactly CHANNELS+3 edges after the edge that sampled the last channel's cReady rise.
- FIFO behaviour:
  - First-word-fall-through; m_data is valid whenever m_valid is high.
  - Pop on m_valid & m_ready.
  - Push while full with a simultaneous pop: both succeed, count unchanged.
  - Push while full without a pop: word dropped, overflow set. overflow clears only on clear or reset.
  - Pointers wrap modulo FIFO_DEPTH. m_data holds its last value when empty.
  - Output order is strict push order.
- clear:
  - Same-cycle effect as reset on everything except the cReady edge-detect register, which keeps tracking.
  - Mid ACC/SAT/PUSH, clear aborts the in-flight result: nothing is pushed, FSM returns to COLLECT.
  - clear beats a simultaneous push or capture.

Optional Feature:
- Macro RESULT_COLLECTOR_RELU_EN.
- Defined: in SAT, a negative clamped result is replaced by 0 (ReLU after saturation).
- Undefined: the signed saturated value is pushed unchanged.

Test Plan:
- CHANNELS=1: cSum=5, bias=3, one-cycle cReady pulse -> m_data=8, m_valid high 4 cycles after the sampling edge, fifo_count=1; m_ready pulse -> count 0.
- CHANNELS=3: cSum=100,-50,7 with ready edges on different cycles; bias=-7 -> m_data=50, 6 cycles after the last edge. cReady held high afterwards -> no second result.
- CHANNELS=2: cSum=0x7FFFFFF0 twice, bias=0x20 -> 0x7FFFFFFF. Sums 0x80000000 twice -> 0x80000000 (macro off).
- FIFO_DEPTH=4, m_ready=0, five results 1..5 -> count=4, overflow=1. Drain yields 1,2,3,4. Push-with-pop at full -> both succeed, no overflow change.
- clear asserted during ACC -> no word pushed, busy=0 next cycle, count=0, overflow=0. Next result then completes normally.
- cSum=-10, bias=0 -> 0 with RESULT_COLLECTOR_RELU_EN defined; 0xFFFFFFF6 without.
